// File: rtl/serial_beta_iter_pkg.sv
// Shared definitions for the serial SWAN beta (S-box) layer.
//   SBOX / INV_SBOX : 4-bit forward and inverse S-box tables
//   state_t         : control FSM states
//   column_get/put  : read/write one 4-bit column {v[c], v[c+C], v[c+2C], v[c+3C]}
//                     of an MSB-first vector padded to MAX_SIDE bits
package swan_pkg;

  localparam int unsigned MAX_SIDE = 128;

  localparam logic [3:0] SBOX [16] = '{
    4'h1, 4'h2, 4'hC, 4'h5, 4'h7, 4'h8, 4'hA, 4'hF,
    4'h4, 4'hD, 4'hB, 4'hE, 4'h9, 4'h6, 4'h0, 4'h3
  };

  localparam logic [3:0] INV_SBOX [16] = '{
    4'hE, 4'h0, 4'h1, 4'hF, 4'h8, 4'h3, 4'hD, 4'h4,
    4'h5, 4'hC, 4'h6, 4'hA, 4'h2, 4'h9, 4'hB, 4'h7
  };

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Bit at the lowest index is the S-box MSB.
  function automatic logic [3:0] column_get(input logic [0:MAX_SIDE-1] vec,
                                            input int unsigned c,
                                            input int unsigned cs);
    logic [6:0] i0, i1, i2, i3;
    i0 = 7'(c);
    i1 = 7'(c + cs);
    i2 = 7'(c + 2 * cs);
    i3 = 7'(c + 3 * cs);
    return {vec[i0], vec[i1], vec[i2], vec[i3]};
  endfunction

  function automatic logic [0:MAX_SIDE-1] column_put(input logic [0:MAX_SIDE-1] vec,
                                                     input int unsigned c,
                                                     input int unsigned cs,
                                                     input logic [3:0] nib);
    logic [0:MAX_SIDE-1] r;
    logic [6:0] i0, i1, i2, i3;
    i0 = 7'(c);
    i1 = 7'(c + cs);
    i2 = 7'(c + 2 * cs);
    i3 = 7'(c + 3 * cs);
    r = vec;
    r[i0] = nib[3];
    r[i1] = nib[2];
    r[i2] = nib[1];
    r[i3] = nib[0];
    return r;
  endfunction

endpackage

// File: rtl/serial_beta_iter_if.sv
// Handshake bundle for serial_beta_iter.
//   in_valid/in_ready : input handshake, x and inv qualified by in_valid
//   out_valid/out_ready : output handshake, y qualified by out_valid
//   master : producer/consumer side, slave : the beta layer
interface serial_beta_iter_if #(
  parameter int unsigned SIDE_SIZE = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [0:SIDE_SIZE-1] x;
  logic                 inv;
  logic                 out_valid;
  logic                 out_ready;
  logic [0:SIDE_SIZE-1] y;

  modport master (
    output in_valid, x, inv, out_ready,
    input  in_ready, out_valid, y
  );

  modport slave (
    input  in_valid, x, inv, out_ready,
    output in_ready, out_valid, y
  );
endinterface

// File: rtl/serial_beta_iter_sbox.sv
// One 4-bit SWAN S-box, forward or inverse, purely combinational.
//   a   : 4-bit input nibble (bit 3 = MSB)
//   inv : 0 = forward table, 1 = inverse table
//   b   : substituted nibble
module sbox4_dual
  import swan_pkg::*;
(
  input  logic [3:0] a,
  input  logic       inv,
  output logic [3:0] b
);
  always_comb begin
    b = inv ? INV_SBOX[a] : SBOX[a];
  end
endmodule

// File: rtl/serial_beta_iter.sv
// Iterative SWAN beta layer: substitutes SBOX_PER_CYCLE 4-bit columns of a
// SIDE_SIZE-bit half-state per clock, ITER cycles per transform.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : slave side of serial_beta_iter_if (in_valid/in_ready/x/inv,
//         out_valid/out_ready/y)
module serial_beta_iter
  import swan_pkg::*;
#(
  parameter int unsigned SIDE_SIZE      = 32,
  parameter int unsigned SBOX_PER_CYCLE = 2,
  parameter int unsigned COLUMN_SIZE    = SIDE_SIZE / 4,
  parameter int unsigned ITER           = COLUMN_SIZE / SBOX_PER_CYCLE
) (
  input logic               clk,
  input logic               rst,
  serial_beta_iter_if.slave bus
);
  localparam int unsigned      IDX_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(ITER - 1);

  state_t               state, state_next;
  logic [IDX_W-1:0]     col_idx;
  logic [0:SIDE_SIZE-1] src, dst, dst_next;
  logic                 mode_inv;
  logic                 in_ready, accept;
  int unsigned          col_base;

  logic [0:MAX_SIDE-1]  src_w, dst_w;
  logic [3:0]           col_in  [SBOX_PER_CYCLE];
  logic [3:0]           col_out [SBOX_PER_CYCLE];

  // Control: in_ready depends only on state and out_ready.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_next = RUN;
      end
      RUN: begin
        if (col_idx == LAST) state_next = DONE;
      end
      DONE: begin
        in_ready = bus.out_ready;
        if (bus.out_ready) state_next = bus.in_valid ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept        = bus.in_valid & in_ready;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state == DONE);
  assign bus.y         = dst;

  // Datapath: vectors are padded to MAX_SIDE so the package column helpers
  // serve every legal SIDE_SIZE.
  assign col_base = 32'(col_idx) * SBOX_PER_CYCLE;

  always_comb begin
    src_w = '0;
    src_w[0:SIDE_SIZE-1] = src;
  end

  for (genvar g = 0; g < SBOX_PER_CYCLE; g++) begin : g_sbox
    assign col_in[g] = column_get(src_w, col_base + 32'(g), COLUMN_SIZE);
    sbox4_dual u_sbox (
      .a   (col_in[g]),
      .inv (mode_inv),
      .b   (col_out[g])
    );
  end

  always_comb begin
    dst_w = '0;
    dst_w[0:SIDE_SIZE-1] = dst;
    for (int unsigned k = 0; k < SBOX_PER_CYCLE; k++) begin
      dst_w = column_put(dst_w, col_base + k, COLUMN_SIZE, col_out[k]);
    end
    dst_next = dst_w[0:SIDE_SIZE-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      col_idx  <= '0;
      src      <= '0;
      dst      <= '0;
      mode_inv <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        src      <= bus.x;
        mode_inv <= bus.inv;
        col_idx  <= '0;
      end else if (state == RUN) begin
        dst <= dst_next;
        if (col_idx != LAST) col_idx <= col_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_beta_iter.sv
// Self-checking bench for serial_beta_iter: a 32-bit/2-per-cycle instance
// for handshake, timing and reset scenarios, plus a group of other
// parameterisations driven in lockstep for round trips and column checks.
module tb_serial_beta_iter;

  localparam logic [3:0] TB_SBOX [16] = '{
    4'h1, 4'h2, 4'hC, 4'h5, 4'h7, 4'h8, 4'hA, 4'hF,
    4'h4, 4'hD, 4'hB, 4'hE, 4'h9, 4'h6, 4'h0, 4'h3
  };

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Main instance
  serial_beta_iter_if #(.SIDE_SIZE(32)) m ();
  serial_beta_iter #(.SIDE_SIZE(32), .SBOX_PER_CYCLE(2)) u_main (
    .clk (clk), .rst (rst), .bus (m)
  );

  // Lockstep group: 32/1, 64/1, 64/16, 128/1, 128/32
  logic [0:127] gx [5];
  logic [0:127] gy [5];
  int unsigned  gside [5] = '{32, 64, 64, 128, 128};
  logic s_in_valid, s_inv, s_out_ready;

  serial_beta_iter_if #(.SIDE_SIZE(32))  g0 ();
  serial_beta_iter_if #(.SIDE_SIZE(64))  g1 ();
  serial_beta_iter_if #(.SIDE_SIZE(64))  g2 ();
  serial_beta_iter_if #(.SIDE_SIZE(128)) g3 ();
  serial_beta_iter_if #(.SIDE_SIZE(128)) g4 ();

  serial_beta_iter #(.SIDE_SIZE(32),  .SBOX_PER_CYCLE(1))  u_g0 (.clk(clk), .rst(rst), .bus(g0));
  serial_beta_iter #(.SIDE_SIZE(64),  .SBOX_PER_CYCLE(1))  u_g1 (.clk(clk), .rst(rst), .bus(g1));
  serial_beta_iter #(.SIDE_SIZE(64),  .SBOX_PER_CYCLE(16)) u_g2 (.clk(clk), .rst(rst), .bus(g2));
  serial_beta_iter #(.SIDE_SIZE(128), .SBOX_PER_CYCLE(1))  u_g3 (.clk(clk), .rst(rst), .bus(g3));
  serial_beta_iter #(.SIDE_SIZE(128), .SBOX_PER_CYCLE(32)) u_g4 (.clk(clk), .rst(rst), .bus(g4));

  assign g0.in_valid = s_in_valid;  assign g0.inv = s_inv;  assign g0.out_ready = s_out_ready;
  assign g1.in_valid = s_in_valid;  assign g1.inv = s_inv;  assign g1.out_ready = s_out_ready;
  assign g2.in_valid = s_in_valid;  assign g2.inv = s_inv;  assign g2.out_ready = s_out_ready;
  assign g3.in_valid = s_in_valid;  assign g3.inv = s_inv;  assign g3.out_ready = s_out_ready;
  assign g4.in_valid = s_in_valid;  assign g4.inv = s_inv;  assign g4.out_ready = s_out_ready;
  assign g0.x = gx[0][0:31];
  assign g1.x = gx[1][0:63];
  assign g2.x = gx[2][0:63];
  assign g3.x = gx[3];
  assign g4.x = gx[4];

  logic g_all_valid;
  assign g_all_valid = g0.out_valid & g1.out_valid & g2.out_valid & g3.out_valid & g4.out_valid;

  // Reference model
  function automatic logic [3:0] tb_inv(input logic [3:0] v);
    logic [3:0] r;
    r = 4'h0;
    for (int j = 0; j < 16; j++) if (TB_SBOX[j] == v) r = 4'(j);
    return r;
  endfunction

  function automatic logic [0:127] model_beta(input logic [0:127] xv, input int unsigned side,
                                              input logic iv);
    logic [0:127] r;
    logic [3:0]   nib, sub;
    int unsigned  cs;
    cs = side / 4;
    r  = '0;
    for (int unsigned c = 0; c < cs; c++) begin
      nib = {xv[c], xv[c + cs], xv[c + 2 * cs], xv[c + 3 * cs]};
      sub = iv ? tb_inv(nib) : TB_SBOX[nib];
      r[c] = sub[3];  r[c + cs] = sub[2];  r[c + 2 * cs] = sub[1];  r[c + 3 * cs] = sub[0];
    end
    return r;
  endfunction

  function automatic logic [0:31] model32(input logic [0:31] xv, input logic iv);
    logic [0:127] p, r;
    p = '0;
    p[0:31] = xv;
    r = model_beta(p, 32, iv);
    return r[0:31];
  endfunction

  // Main-instance drivers (all called at a negedge)
  task automatic m_send(input logic [0:31] xv, input logic iv);
    m.x = xv;  m.inv = iv;  m.in_valid = 1'b1;
    @(negedge clk);
    m.in_valid = 1'b0;
  endtask

  // n = cycles from the accept cycle to the first out_valid cycle, -1 on timeout
  task automatic m_wait(output int n);
    n = 1;
    while (m.out_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (m.out_valid !== 1'b1) n = -1;
  endtask

  task automatic m_release();
    m.out_ready = 1'b1;
    @(negedge clk);
    m.out_ready = 1'b0;
  endtask

  // Group driver: one transform on every group instance, results in gy
  task automatic g_run(input logic iv, output logic timeout);
    int n;
    s_inv = iv;  s_in_valid = 1'b1;
    @(negedge clk);
    s_in_valid = 1'b0;
    n = 0;
    while (g_all_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    timeout = (g_all_valid !== 1'b1);
    for (int i = 0; i < 5; i++) gy[i] = '0;
    gy[0][0:31] = g0.y;
    gy[1][0:63] = g1.y;
    gy[2][0:63] = g2.y;
    gy[3]       = g3.y;
    gy[4]       = g4.y;
    s_out_ready = 1'b1;
    @(negedge clk);
    s_out_ready = 1'b0;
  endtask

  task automatic g_fill();
    for (int i = 0; i < 5; i++) begin
      gx[i] = {$urandom, $urandom, $urandom, $urandom};
      for (int unsigned b = gside[i]; b < 128; b++) gx[i][b] = 1'b0;
    end
  endtask

  // Tests
  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (m.in_ready !== 1'b1 || m.out_valid !== 1'b0 || m.y !== 32'h0) begin
      failures++;
      $display("FAIL reset_hold: in_ready=%b out_valid=%b y=%h, want 1 0 00000000",
               m.in_ready, m.out_valid, m.y);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (m.in_ready !== 1'b1 || m.out_valid !== 1'b0 || m.y !== 32'h0 || g3.y !== 128'h0) begin
      failures++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b y=%h g3.y=%h, want 1 0 0 0",
               m.in_ready, m.out_valid, m.y, g3.y);
    end
  endtask

  task automatic test_zero();
    int n;
    m_send(32'h0, 1'b0);
    m_wait(n);
    checks++;
    if (n !== 5) begin
      failures++;
      $display("FAIL zero_latency: got %0d cycles, want 5", n);
    end
    checks++;
    if (m.y !== model32(32'h0, 1'b0)) begin
      failures++;
      $display("FAIL zero_value: y=%h want %h", m.y, model32(32'h0, 1'b0));
    end
    m_release();
    checks++;
    if (m.out_valid !== 1'b0 || m.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL zero_drain: out_valid=%b in_ready=%b, want 0 1", m.out_valid, m.in_ready);
    end
  endtask

  task automatic test_round_trip();
    int n;
    logic [0:31] xv, y1;
    for (int t = 0; t < 4; t++) begin
      xv = (t == 0) ? 32'h0123_4567 : 32'($urandom);
      m_send(xv, 1'b0);
      m_wait(n);
      y1 = m.y;
      checks++;
      if (n !== 5 || y1 !== model32(xv, 1'b0)) begin
        failures++;
        $display("FAIL rt_forward: x=%h lat=%0d y=%h want lat 5 y=%h", xv, n, y1, model32(xv, 1'b0));
      end
      m_release();
      m_send(y1, 1'b1);
      m_wait(n);
      checks++;
      if (n !== 5 || m.y !== xv) begin
        failures++;
        $display("FAIL rt_inverse: lat=%0d y=%h want lat 5 y=%h", n, m.y, xv);
      end
      m_release();
    end
  endtask

  task automatic test_backpressure();
    int n;
    logic [0:31] x1, x2, yexp;
    logic        i1, i2;
    x1 = 32'($urandom);  i1 = 1'($urandom);
    m_send(x1, i1);
    m_wait(n);
    yexp = model32(x1, i1);
    checks++;
    if (n !== 5 || m.y !== yexp) begin
      failures++;
      $display("FAIL bp_first: lat=%0d y=%h want lat 5 y=%h", n, m.y, yexp);
    end
    for (int k = 0; k < 10; k++) begin
      m.in_valid = 1'b1;  m.x = 32'($urandom);  m.inv = 1'($urandom);
      @(negedge clk);
      checks++;
      if (m.out_valid !== 1'b1 || m.in_ready !== 1'b0 || m.y !== yexp) begin
        failures++;
        $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b y=%h want 1 0 %h",
                 k, m.out_valid, m.in_ready, m.y, yexp);
      end
    end
    x2 = 32'($urandom);  i2 = 1'($urandom);
    m.x = x2;  m.inv = i2;  m.in_valid = 1'b1;  m.out_ready = 1'b1;
    #1;
    checks++;
    if (m.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release_ready: in_ready=%b want 1", m.in_ready);
    end
    @(negedge clk);
    m.in_valid = 1'b0;  m.out_ready = 1'b0;
    checks++;
    if (m.out_valid !== 1'b0 || m.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_accepted: out_valid=%b in_ready=%b want 0 0", m.out_valid, m.in_ready);
    end
    m_wait(n);
    checks++;
    if (n !== 5 || m.y !== model32(x2, i2)) begin
      failures++;
      $display("FAIL bp_second: lat=%0d y=%h want lat 5 y=%h", n, m.y, model32(x2, i2));
    end
    m_release();
  endtask

  task automatic test_mid_reset();
    int n;
    logic [0:31] xv;
    m_send(32'($urandom), 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (m.out_valid !== 1'b0 || m.y !== 32'h0 || m.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_now: out_valid=%b y=%h in_ready=%b want 0 00000000 1",
               m.out_valid, m.y, m.in_ready);
    end
    #4 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (m.in_ready !== 1'b1 || m.out_valid !== 1'b0 || m.y !== 32'h0) begin
      failures++;
      $display("FAIL mid_reset_after: in_ready=%b out_valid=%b y=%h want 1 0 0",
               m.in_ready, m.out_valid, m.y);
    end
    xv = 32'($urandom);
    m_send(xv, 1'b1);
    m_wait(n);
    checks++;
    if (n !== 5 || m.y !== model32(xv, 1'b1)) begin
      failures++;
      $display("FAIL mid_reset_next: lat=%0d y=%h want lat 5 y=%h", n, m.y, model32(xv, 1'b1));
    end
    m_release();
  endtask

  task automatic test_mode_isolation();
    int n;
    logic [0:31] x0;
    logic        i0;
    for (int t = 0; t < 4; t++) begin
      x0 = 32'($urandom);  i0 = 1'(t);
      m.x = x0;  m.inv = i0;  m.in_valid = 1'b1;
      @(negedge clk);
      n = 1;
      while (m.out_valid !== 1'b1 && n < 200) begin
        m.x = 32'($urandom);  m.inv = ~m.inv;  m.in_valid = 1'($urandom);
        @(negedge clk);
        n++;
      end
      m.in_valid = 1'b0;
      checks++;
      if (n !== 5 || m.y !== model32(x0, i0)) begin
        failures++;
        $display("FAIL mode_iso[%0d]: lat=%0d y=%h want lat 5 y=%h", t, n, m.y, model32(x0, i0));
      end
      m_release();
    end
  endtask

  task automatic test_back_to_back();
    logic [0:31] q [$];
    logic [0:31] xr, ye;
    logic        ir;
    int          got, last;
    got = 0;  last = -1;
    m.out_ready = 1'b1;
    for (int i = 0; i < 120; i++) begin
      if (m.out_valid === 1'b1) begin
        ye = (q.size() > 0) ? q.pop_front() : 32'hx;
        checks++;
        if (m.y !== ye) begin
          failures++;
          $display("FAIL b2b_data[%0d]: y=%h want %h", got, m.y, ye);
        end
        if (last >= 0) begin
          checks++;
          if (i - last !== 5) begin
            failures++;
            $display("FAIL b2b_interval[%0d]: got %0d cycles want 5", got, i - last);
          end
        end
        got++;
        last = i;
      end
      if (i < 31) begin
        xr = 32'($urandom);  ir = 1'($urandom);
        m.x = xr;  m.inv = ir;  m.in_valid = 1'b1;
        if (m.in_ready === 1'b1) q.push_back(model32(xr, ir));
      end else begin
        m.in_valid = 1'b0;
        if (q.size() == 0) break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    m.out_ready = 1'b0;
    checks++;
    if (got !== 7) begin
      failures++;
      $display("FAIL b2b_count: got %0d results want 7", got);
    end
  endtask

  task automatic test_wide_round_trip();
    logic [0:127] orig [5];
    logic         to;
    for (int t = 0; t < 3; t++) begin
      g_fill();
      for (int i = 0; i < 5; i++) orig[i] = gx[i];
      g_run(1'b0, to);
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (to || gy[i] !== model_beta(orig[i], gside[i], 1'b0)) begin
          failures++;
          $display("FAIL wide_fwd[%0d]: timeout=%b y=%h want %h", i, to, gy[i],
                   model_beta(orig[i], gside[i], 1'b0));
        end
        gx[i] = gy[i];
      end
      g_run(1'b1, to);
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (to || gy[i] !== orig[i]) begin
          failures++;
          $display("FAIL wide_inv[%0d]: timeout=%b y=%h want %h", i, to, gy[i], orig[i]);
        end
      end
    end
  endtask

  task automatic test_exhaustive_column();
    logic [3:0] vn, col, ce;
    logic       to;
    for (int v = 0; v < 16; v++) begin
      for (int iv = 0; iv < 2; iv++) begin
        vn = 4'(v);
        g_fill();
        gx[0][7] = vn[3];  gx[0][15] = vn[2];  gx[0][23] = vn[1];  gx[0][31] = vn[0];
        g_run(1'(iv), to);
        col = {gy[0][7], gy[0][15], gy[0][23], gy[0][31]};
        ce  = (iv != 0) ? tb_inv(vn) : TB_SBOX[vn];
        checks++;
        if (to || col !== ce) begin
          failures++;
          $display("FAIL col7 v=%h inv=%0d: timeout=%b got %h want %h", vn, iv, to, col, ce);
        end
        checks++;
        if (gy[0] !== model_beta(gx[0], 32, 1'(iv))) begin
          failures++;
          $display("FAIL col7_rest v=%h inv=%0d: y=%h want %h", vn, iv, gy[0][0:31],
                   model_beta(gx[0], 32, 1'(iv)));
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    m.in_valid = 1'b0;  m.x = '0;  m.inv = 1'b0;  m.out_ready = 1'b0;
    s_in_valid = 1'b0;  s_inv = 1'b0;  s_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) gx[i] = '0;
    test_reset();
    test_zero();
    test_round_trip();
    test_backpressure();
    test_mid_reset();
    test_mode_isolation();
    test_back_to_back();
    test_wide_round_trip();
    test_exhaustive_column();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
